// File: rtl/decode_pkg.sv
// Shared constants for the fetch-side feed queue and the format decoders.
// Format indices are bit positions in the one-hot format code.
package decode_pkg;

    localparam int addressWidthDef = 64;
    localparam int instructionWidthDef = 32;
    localparam int pidSizeDef = 20;
    localparam int tidSizeDef = 16;
    localparam int instructionCounterWidthDef = 64;
    localparam int primOpcodeSizeDef = 6;
    localparam int formatWidthDef = 26;
    localparam int depthDef = 4;

    localparam int fmtA = 0;
    localparam int fmtB = 1;
    localparam int fmtD = 2;
    localparam int fmtDS = 3;
    localparam int fmtI = 5;
    localparam int fmtSC = 6;
    localparam int fmtXL = 7;
    localparam int fmtX = 8;

    localparam int opAddi = 14;
    localparam int opAddis = 15;
    localparam int opBc = 16;
    localparam int opSc = 17;
    localparam int opB = 18;
    localparam int opXl = 19;
    localparam int opX = 31;
    localparam int opDFirst = 32;
    localparam int opDLast = 55;
    localparam int opDs58 = 58;
    localparam int opFpS = 59;
    localparam int opDs62 = 62;
    localparam int opFp = 63;

endpackage

// File: rtl/primary_opcode_classifier.sv
// Maps a primary opcode to its one-hot instruction format.
// Unmapped opcodes yield a zero format and raise illegal.
module primary_opcode_classifier
    import decode_pkg::*;
#(
    parameter int PrimOpcodeSize = primOpcodeSizeDef,
    parameter int formatWidth = formatWidthDef
) (
    input  logic [PrimOpcodeSize-1:0] opcode,
    output logic [formatWidth-1:0]    instFormat,
    output logic                      illegal
);

    localparam logic [formatWidth-1:0] oneHot = formatWidth'(1);

    function automatic logic isOp(
        input logic [PrimOpcodeSize-1:0] op,
        input int                        code
    );
        return op == PrimOpcodeSize'(code);
    endfunction

    logic isDRange;

    assign isDRange = (opcode >= PrimOpcodeSize'(opDFirst))
                   && (opcode <= PrimOpcodeSize'(opDLast));

    always_comb begin
        instFormat = '0;
        illegal = 1'b0;
        unique case (1'b1)
            isOp(opcode, opFpS) || isOp(opcode, opFp):
                instFormat = oneHot << fmtA;
            isOp(opcode, opBc):
                instFormat = oneHot << fmtB;
            isOp(opcode, opAddi) || isOp(opcode, opAddis) || isDRange:
                instFormat = oneHot << fmtD;
            isOp(opcode, opDs58) || isOp(opcode, opDs62):
                instFormat = oneHot << fmtDS;
            isOp(opcode, opB):
                instFormat = oneHot << fmtI;
            isOp(opcode, opSc):
                instFormat = oneHot << fmtSC;
            isOp(opcode, opXl):
                instFormat = oneHot << fmtXL;
            isOp(opcode, opX):
                instFormat = oneHot << fmtX;
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_feed_queue.sv
// Fetch-side FIFO feeding the format decoders with classified, ID-stamped words.
// Define DECODE_FEED_PERF_EN to add saturating issue/stall performance counters.
module decode_feed_queue
    import decode_pkg::*;
#(
    parameter int addressWidth = addressWidthDef,
    parameter int instructionWidth = instructionWidthDef,
    parameter int PidSize = pidSizeDef,
    parameter int TidSize = tidSizeDef,
    parameter int instructionCounterWidth = instructionCounterWidthDef,
    parameter int PrimOpcodeSize = primOpcodeSizeDef,
    parameter int formatWidth = formatWidthDef,
    parameter int depth = depthDef
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               fetchEnable_i,
    input  logic [instructionWidth-1:0]        fetchInstruction_i,
    input  logic [addressWidth-1:0]            fetchAddress_i,
    input  logic                               fetchIs64Bit_i,
    input  logic [PidSize-1:0]                 fetchPid_i,
    input  logic [TidSize-1:0]                 fetchTid_i,
    output logic                               ready_o,
    input  logic                               stall_i,
    output logic                               enable_o,
    output logic [formatWidth-1:0]             instFormat_o,
    output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o,
    output logic                               illegal_o
`ifdef DECODE_FEED_PERF_EN
    ,
    output logic [31:0]                        perfIssued_o,
    output logic [31:0]                        perfStallCycles_o
`endif
);

    localparam int ptrW = $clog2(depth);
    localparam int cntW = ptrW + 1;

    logic [instructionWidth-1:0] memInstr [depth];
    logic [addressWidth-1:0]     memAddr  [depth];
    logic                        memIs64  [depth];
    logic [PidSize-1:0]          memPid   [depth];
    logic [TidSize-1:0]          memTid   [depth];

    logic [ptrW-1:0]                    rdPtr;
    logic [ptrW-1:0]                    wrPtr;
    logic [cntW-1:0]                    count;
    logic [instructionCounterWidth-1:0] majId;

    logic                      push;
    logic                      pop;
    logic [PrimOpcodeSize-1:0] headOpcode;
    logic [formatWidth-1:0]    headFormat;
    logic                      headIllegal;

    assign ready_o = count < cntW'(depth);
    assign push = fetchEnable_i && ready_o;
    assign pop = !stall_i && (count != '0);
    // Primary opcode lives in the POWER big-endian bits [0:5], i.e. the MSBs.
    assign headOpcode = memInstr[rdPtr][instructionWidth-1 -: PrimOpcodeSize];

    primary_opcode_classifier #(
        .PrimOpcodeSize(PrimOpcodeSize),
        .formatWidth(formatWidth)
    ) classifier (
        .opcode(headOpcode),
        .instFormat(headFormat),
        .illegal(headIllegal)
    );

    always_ff @(posedge clock_i) begin
        if (push) begin
            memInstr[wrPtr] <= fetchInstruction_i;
            memAddr[wrPtr] <= fetchAddress_i;
            memIs64[wrPtr] <= fetchIs64Bit_i;
            memPid[wrPtr] <= fetchPid_i;
            memTid[wrPtr] <= fetchTid_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            majId <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
                majId <= majId + 1'b1;
            end
            count <= count + cntW'(push) - cntW'(pop);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            enable_o <= 1'b0;
            instFormat_o <= '0;
            instructionOpcode_o <= '0;
            instruction_o <= '0;
            instructionAddress_o <= '0;
            is64Bit_o <= 1'b0;
            instructionPid_o <= '0;
            instructionTid_o <= '0;
            instructionMajId_o <= '0;
            illegal_o <= 1'b0;
        end else begin
            enable_o <= pop;
            if (pop) begin
                instFormat_o <= headFormat;
                instructionOpcode_o <= headOpcode;
                instruction_o <= memInstr[rdPtr];
                instructionAddress_o <= memAddr[rdPtr];
                is64Bit_o <= memIs64[rdPtr];
                instructionPid_o <= memPid[rdPtr];
                instructionTid_o <= memTid[rdPtr];
                instructionMajId_o <= majId;
                illegal_o <= headIllegal;
            end
        end
    end

`ifdef DECODE_FEED_PERF_EN
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            perfIssued_o <= '0;
            perfStallCycles_o <= '0;
        end else begin
            if (pop && perfIssued_o != '1) begin
                perfIssued_o <= perfIssued_o + 1'b1;
            end
            if (stall_i && count != '0 && perfStallCycles_o != '1) begin
                perfStallCycles_o <= perfStallCycles_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_feed_queue.sv
// Directed bench for decode_feed_queue with a queue-based scoreboard.
// Major ID counter is narrowed to 8 bits so the wrap is reachable.
module tb_decode_feed_queue;

    localparam int CW = 8;
    localparam int DEPTH = 4;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          fetchEnable_i = 1'b0;
    logic [31:0]   fetchInstruction_i = '0;
    logic [63:0]   fetchAddress_i = '0;
    logic          fetchIs64Bit_i = 1'b0;
    logic [19:0]   fetchPid_i = '0;
    logic [15:0]   fetchTid_i = '0;
    logic          ready_o;
    logic          stall_i = 1'b0;
    logic          enable_o;
    logic [25:0]   instFormat_o;
    logic [5:0]    instructionOpcode_o;
    logic [31:0]   instruction_o;
    logic [63:0]   instructionAddress_o;
    logic          is64Bit_o;
    logic [19:0]   instructionPid_o;
    logic [15:0]   instructionTid_o;
    logic [CW-1:0] instructionMajId_o;
    logic          illegal_o;
`ifdef DECODE_FEED_PERF_EN
    logic [31:0]   perfIssued_o;
    logic [31:0]   perfStallCycles_o;
`endif

    decode_feed_queue #(
        .instructionCounterWidth(CW),
        .depth(DEPTH)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .fetchEnable_i(fetchEnable_i),
        .fetchInstruction_i(fetchInstruction_i),
        .fetchAddress_i(fetchAddress_i),
        .fetchIs64Bit_i(fetchIs64Bit_i),
        .fetchPid_i(fetchPid_i),
        .fetchTid_i(fetchTid_i),
        .ready_o(ready_o),
        .stall_i(stall_i),
        .enable_o(enable_o),
        .instFormat_o(instFormat_o),
        .instructionOpcode_o(instructionOpcode_o),
        .instruction_o(instruction_o),
        .instructionAddress_o(instructionAddress_o),
        .is64Bit_o(is64Bit_o),
        .instructionPid_o(instructionPid_o),
        .instructionTid_o(instructionTid_o),
        .instructionMajId_o(instructionMajId_o),
        .illegal_o(illegal_o)
`ifdef DECODE_FEED_PERF_EN
        ,
        .perfIssued_o(perfIssued_o),
        .perfStallCycles_o(perfStallCycles_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [31:0]   instr;
        logic [63:0]   addr;
        logic          is64;
        logic [19:0]   pid;
        logic [15:0]   tid;
        logic [CW-1:0] id;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] expId = '0;
    int            errors = 0;
    int            checks = 0;
    logic          lastAcc;

    // Reference format map: {illegal, format}.
    function automatic logic [26:0] fmtOf(input logic [5:0] op);
        case (op) inside
            6'd59, 6'd63:   return {1'b0, 26'd1};
            6'd16:          return {1'b0, 26'd2};
            6'd14, 6'd15,
            [6'd32:6'd55]:  return {1'b0, 26'd4};
            6'd58, 6'd62:   return {1'b0, 26'd8};
            6'd18:          return {1'b0, 26'd32};
            6'd17:          return {1'b0, 26'd64};
            6'd19:          return {1'b0, 26'd128};
            6'd31:          return {1'b0, 26'd256};
            default:        return {1'b1, 26'd0};
        endcase
    endfunction

    task automatic chk(
        input string        tag,
        input logic [127:0] obs,
        input logic [127:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(
        input logic        fe,
        input logic [31:0] w,
        input logic        st,
        input logic        rst = 1'b1
    );
        exp_t e;
        exp_t h;
        logic pop;
        logic acc;
        reset_i = rst;
        fetchEnable_i = fe;
        fetchInstruction_i = w;
        fetchAddress_i = {$urandom, $urandom};
        fetchIs64Bit_i = 1'($urandom);
        fetchPid_i = 20'($urandom);
        fetchTid_i = 16'($urandom);
        stall_i = st;
        pop = rst && !st && sb.size() > 0;
        acc = rst && fe && sb.size() < DEPTH;
        e.instr = w;
        e.addr = fetchAddress_i;
        e.is64 = fetchIs64Bit_i;
        e.pid = fetchPid_i;
        e.tid = fetchTid_i;
        e.id = expId;
        @(posedge clock_i);
        #1;
        h = e;
        if (!rst) begin
            sb.delete();
            expId = '0;
        end else begin
            if (pop) h = sb.pop_front();
            if (acc) begin
                sb.push_back(e);
                expId++;
            end
        end
        lastAcc = acc;
        chk("ready", 128'(ready_o), 128'(sb.size() < DEPTH));
        chk("enable", 128'(enable_o), 128'(pop));
        if (pop) begin
            chk("instr", 128'(instruction_o), 128'(h.instr));
            chk("opcode", 128'(instructionOpcode_o), 128'(h.instr[31:26]));
            chk("format", 128'(instFormat_o), 128'(fmtOf(h.instr[31:26]) & 27'h3FFFFFF));
            chk("illegal", 128'(illegal_o), 128'(fmtOf(h.instr[31:26]) >> 26));
            chk("addr", 128'(instructionAddress_o), 128'(h.addr));
            chk("is64", 128'(is64Bit_o), 128'(h.is64));
            chk("pid", 128'(instructionPid_o), 128'(h.pid));
            chk("tid", 128'(instructionTid_o), 128'(h.tid));
            chk("majId", 128'(instructionMajId_o), 128'(h.id));
        end
    endtask

    initial begin
        int op;
        logic tog;
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("rst_enable", 128'(enable_o), 128'(0));
        chk("rst_ready", 128'(ready_o), 128'(1));
        chk("rst_format", 128'(instFormat_o), 128'(0));
        chk("rst_opcode", 128'(instructionOpcode_o), 128'(0));
        chk("rst_instr", 128'(instruction_o), 128'(0));
        chk("rst_addr", 128'(instructionAddress_o), 128'(0));
        chk("rst_is64", 128'(is64Bit_o), 128'(0));
        chk("rst_pid", 128'(instructionPid_o), 128'(0));
        chk("rst_tid", 128'(instructionTid_o), 128'(0));
        chk("rst_majId", 128'(instructionMajId_o), 128'(0));
        chk("rst_illegal", 128'(illegal_o), 128'(0));

        step(1'b1, 32'h41C7_03FF, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("bc_enable", 128'(enable_o), 128'(1));
        chk("bc_format", 128'(instFormat_o), 128'(2));
        chk("bc_opcode", 128'(instructionOpcode_o), 128'(16));
        chk("bc_majId", 128'(instructionMajId_o), 128'(0));
        chk("bc_illegal", 128'(illegal_o), 128'(0));

        for (int i = 0; i < 5; i++) begin
            step(1'b1, {6'd31, 26'($urandom)}, 1'b1);
            chk("full_accept", 128'(lastAcc), 128'(i < 4));
        end
        chk("full_ready", 128'(ready_o), 128'(0));
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);

        op = 0;
        tog = 1'b0;
        while (op < 63) begin
            step(1'b1, {6'(op), 26'($urandom)}, tog);
            if (lastAcc) op++;
            tog = ~tog;
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);

        step(1'b1, {6'd1, 26'h155}, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("op1_illegal", 128'(illegal_o), 128'(1));
        chk("op1_format", 128'(instFormat_o), 128'(0));

        for (int i = 0; i < 3; i++) step(1'b1, {6'd14, 26'($urandom)}, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        step(1'b1, {6'd63, 26'($urandom)}, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("postrst_majId", 128'(instructionMajId_o), 128'(0));
        chk("postrst_enable", 128'(enable_o), 128'(1));

        for (int i = 0; i < 254; i++) step(1'b1, {6'd32, 26'($urandom)}, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, {6'd18, 26'($urandom)}, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("wrap_hi", 128'(instructionMajId_o), 128'(8'hFF));
        step(1'b1, {6'd17, 26'($urandom)}, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("wrap_lo", 128'(instructionMajId_o), 128'(0));
        chk("drained", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
